alm_mac_dotprod: RTL
====================

Name: alm_mac_dotprod

Overview:
Parametrised multi-lane multiply-accumulate engine, successor to the single-lane 8-bit ALM MAC. Each accepted beat multiplies LANES operand pairs, reduces them through an adder tree and accumulates into a vector-length dot product. It adds a valid/first/last framing handshake, signed/unsigned operand mode, optional saturation and a sticky overflow flag. It sits between the operand buffers and the result collection logic in the ALM compute tile.

Parameters:
A_W, 8, operand A width per lane
B_W, 8, operand B width per lane
LANES, 4, parallel multiplier lanes per beat (>=1)
ACC_W, 27, accumulator/result width, two's complement (>= A_W+B_W+clog2(LANES)+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  beat present on a/b this cycle
in_first  in  1  beat starts a new vector; qualified by in_valid
in_last  in  1  beat ends the vector; qualified by in_valid
signed_mode  in  1  1: operands signed; 0: operands unsigned; sampled per beat
sat_en  in  1  1: saturate accumulator; 0: wrap; sampled per beat
a  in  LANES*A_W  lane i operand in bits [i*A_W +: A_W]
b  in  LANES*B_W  lane i operand in bits [i*B_W +: B_W]
out_valid  out  1  one-cycle pulse, result holds a completed dot product
result  out  ACC_W  final accumulated value, held until next completion
overflow  out  1  sticky; set if any accumulation in the current/just-finished vector overflowed ACC_W

Behaviour:
- Reset (async, any time, including mid-vector): all pipeline valids, accumulator, result, out_valid, overflow -> 0. The partial vector is discarded, and the first beat after release loads the accumulator.
- Stage 1 (edge k, in_valid=1): register LANES products (sign- or zero-extended per signed_mode to A_W+B_W+1 bits) plus first/last/sat_en tags. in_valid=0: stage-1 valid <= 0 and products are don't-care.
- Stage 2 (edge k+1, stage-1 valid): sum = sign-extended sum of all lane products. "Load" beat = tag first=1 OR previous accepted beat had last=1 (or first beat after reset). Load: acc <= sum. Else: acc <= acc + sum at ACC_W+1 bits, then range check.
- Overflow: if true sum exceeds the signed ACC_W range: sat_en=1 clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1); sat_en=0 wraps modulo 2^ACC_W. Either way overflow <= 1. overflow clears on a load beat, then ORs in that beat's overflow.
- If the stage-2 beat has last=1: result <= new acc value and out_valid <= 1 on the same edge k+1. Latency is 2 cycles from the sampled beat to out_valid. out_valid = 0 otherwise. result is held between completions.
- in_first=in_last=1 on one beat: single-beat vector, result = lane sum.
- Bubbles (in_valid=0) mid-vector: the accumulator holds; no timeout.
- Back-to-back vectors at full rate: a last beat followed immediately by the next first beat has no gap requirement, and out_valid pulses for each.
- in_first/in_last/mode inputs are ignored when in_valid=0.
- Throughput: 1 beat per cycle, no backpressure.

Test Plan:
- Single beat, LANES=4, signed: a={65,-99,8,4}, b={-121,-70,9,7} (lane3..0), first=last=1 -> out_valid pulse 2 cycles later, result=-835, overflow=0.
- Same 4 pairs as 4 beats on lane 0 only (other lanes 0), first on beat 1, last on beat 4, one bubble between beats 2 and 3 -> single out_valid, result=-835, no pulse earlier.
- Unsigned mode: lane0 a=255,b=255, others 0, single beat -> result=65025. The same bits in signed mode -> result=1.
- ACC_W=18, signed, all lanes a=b=-128, 2 beats. With sat_en=1 -> result=131071, overflow=1. With sat_en=0 -> result=-131072, overflow=1. The next vector's first beat clears overflow.
- Back-to-back vectors: beat (first,last) then beat (first,last) with lane-sum values 10 and -3 on consecutive cycles -> out_valid high on two consecutive cycles, results 10 then -3.
- Assert reset for 1 cycle between beats 2 and 3 of a 4-beat vector -> out_valid, result, overflow go 0 immediately. The following beats with no in_first load fresh, so result equals the sum of the post-reset beats only.

Source files
------------

// File: rtl/alm_mac_dotprod.sv
// alm_mac_dotprod: multi-lane multiply-accumulate dot-product engine.
// Stage 1 registers per-lane products, stage 2 reduces them and accumulates
// into a framed dot product with optional saturation and a sticky overflow.
module alm_mac_dotprod #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 27
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic                   signed_mode,
  input  logic                   sat_en,
  input  logic [LANES*A_W-1:0]   a,
  input  logic [LANES*B_W-1:0]   b,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       result,
  output logic                   overflow
);

  localparam int P_W = A_W + B_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [P_W-1:0] prod_c  [LANES];
  logic signed [P_W-1:0] s1_prod [LANES];
  logic                  s1_valid;
  logic                  s1_first;
  logic                  s1_last;
  logic                  s1_sat;

  logic [ACC_W-1:0]      acc;
  logic                  need_load;

  logic [ACC_W:0]        sum_c;
  logic [ACC_W:0]        acc_ext_c;
  logic                  load_c;
  logic                  ovf_c;
  logic [ACC_W-1:0]      acc_next_c;
  logic                  ovf_next_c;

  // Per-lane operands extended to the product width; every product of two
  // A_W/B_W operands (signed or unsigned) fits exactly in P_W signed bits.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [P_W-1:0] ax;
    logic signed [P_W-1:0] bx;
    logic                  a_ext;
    logic                  b_ext;
    assign a_ext     = signed_mode & a[i*A_W + A_W - 1];
    assign b_ext     = signed_mode & b[i*B_W + B_W - 1];
    assign ax        = {{(B_W+1){a_ext}}, a[i*A_W +: A_W]};
    assign bx        = {{(A_W+1){b_ext}}, b[i*B_W +: B_W]};
    assign prod_c[i] = ax * bx;
  end

  // Stage 1 control: beat valid and framing/saturation tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_sat   <= sat_en;
    end
  end

  // Stage 1 data: products only matter when the tag says valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int unsigned i = 0; i < LANES; i++) s1_prod[i] <= prod_c[i];
    end
  end

  // Adder tree: sign-extended sum of all lane products at ACC_W+1 bits.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_c = sum_c + {{(ACC_W+1-P_W){s1_prod[i][P_W-1]}}, s1_prod[i]};
    end
  end

  // Accumulate with range check; the extra top bit exposes signed overflow.
  always_comb begin
    load_c     = s1_first | need_load;
    acc_ext_c  = load_c ? sum_c : ({acc[ACC_W-1], acc} + sum_c);
    ovf_c      = acc_ext_c[ACC_W] ^ acc_ext_c[ACC_W-1];
    acc_next_c = acc_ext_c[ACC_W-1:0];
    if (ovf_c && s1_sat) acc_next_c = acc_ext_c[ACC_W] ? ACC_MIN : ACC_MAX;
    ovf_next_c = (overflow & ~load_c) | ovf_c;
  end

  // Stage 2: accumulator, sticky overflow and completed-result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      need_load <= 1'b1;
      result    <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        acc       <= acc_next_c;
        overflow  <= ovf_next_c;
        need_load <= s1_last;
        if (s1_last) result <= acc_next_c;
      end
    end
  end

endmodule
